// File: rtl/level_column_feeder.sv
// Level column feeder: streams 30-bit block columns from the synchronous level ROM
// into a double buffer (front drives new_block_id, back is the assembly buffer).
// Optional feature macro LEVEL_LOOP_EN: wrap the level back to column 0 instead of
// generating air columns past the end of the ROM.
module level_column_feeder #(
  parameter int unsigned NUM_ROWS   = 10,
  parameter int unsigned CELL_W     = 3,
  parameter int unsigned LEVEL_COLS = 212,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Shift,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [CELL_W-1:0]          rom_data,
  output logic [NUM_ROWS*CELL_W-1:0] new_block_id,
  output logic                       col_valid,
  output logic [7:0]                 front_col,
  output logic                       level_end,
  output logic                       underrun
);

  localparam int unsigned ColW = NUM_ROWS * CELL_W;
  localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LEVEL_COLS * NUM_ROWS - 1);
  localparam logic [RowW-1:0]   LastRow  = RowW'(NUM_ROWS - 1);

  typedef enum logic [1:0] {StFetch, StDrain, StHold} state_e;

  state_e              state_q, state_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ColW-1:0]     back_q, back_d;
  logic [ColW-1:0]     front_q, front_d;
  logic                back_full_q, back_full_d;
  logic                col_valid_q, col_valid_d;
  logic [7:0]          front_col_q, front_col_d;
  logic                level_end_q, level_end_d;
  logic                underrun_q, underrun_d;
  // air_q: fetch pointer has run past the last ROM column (all further columns are air)
  logic                air_q, air_d;
  // wrap_q: column being assembled/held is the wrapped column 0
  logic                wrap_q, wrap_d;

  logic                done;
  logic [ColW-1:0]     done_col;
  logic                load_front;
  logic [ColW-1:0]     load_col;
  logic                start_next;

  // Next-state: fetch sequencing, buffer movement, Shift handling and fetch pointer.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    rom_addr_d  = rom_addr_q;
    back_d      = back_q;
    front_d     = front_q;
    back_full_d = back_full_q;
    col_valid_d = col_valid_q;
    front_col_d = front_col_q;
    underrun_d  = underrun_q;
    air_d       = air_q;
    wrap_d      = wrap_q;
    done        = 1'b0;
    done_col    = '0;
    load_front  = 1'b0;
    load_col    = '0;
    start_next  = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (air_q) begin
          done = 1'b1;
        end else begin
          // Data for the previous cycle's address lands in slot row-1.
          for (int r = 1; r < NUM_ROWS; r++) begin
            if (row_q == RowW'(r)) back_d[CELL_W*r - CELL_W +: CELL_W] = rom_data;
          end
          if (row_q == LastRow) begin
            state_d = StDrain;
          end else begin
            row_d      = row_q + RowW'(1);
            rom_addr_d = rom_addr_q + ADDR_W'(1);
          end
        end
      end
      StDrain: begin
        done                       = 1'b1;
        done_col                   = back_q;
        done_col[ColW-1 -: CELL_W] = rom_data;
      end
      StHold: begin
        if (Shift) begin
          load_front  = 1'b1;
          load_col    = back_q;
          back_full_d = 1'b0;
          start_next  = 1'b1;
        end
      end
      default: state_d = StFetch;
    endcase

    // A finished column bypasses back when front is free or being consumed now.
    if (done) begin
      if (!col_valid_q || Shift) begin
        load_front = 1'b1;
        load_col   = done_col;
        start_next = 1'b1;
      end else begin
        back_d      = done_col;
        back_full_d = 1'b1;
        state_d     = StHold;
      end
    end

    if (load_front) begin
      front_d     = load_col;
      col_valid_d = 1'b1;
      if (wrap_q)                     front_col_d = '0;
      else if (col_valid_q && Shift)  front_col_d = front_col_q + 8'd1;
    end else if (Shift && col_valid_q) begin
      col_valid_d = 1'b0;
      front_col_d = front_col_q + 8'd1;
    end

    if (Shift && !col_valid_q) underrun_d = 1'b1;

    if (start_next) begin
      state_d = StFetch;
      row_d   = '0;
      if (!air_q) begin
        if (rom_addr_q == LastAddr) begin
`ifdef LEVEL_LOOP_EN
          rom_addr_d = '0;
          wrap_d     = 1'b1;
`else
          air_d      = 1'b1;
`endif
        end else begin
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          wrap_d     = 1'b0;
        end
      end
    end

`ifdef LEVEL_LOOP_EN
    level_end_d = load_front && wrap_q;
`else
    level_end_d = ({24'd0, front_col_d} >= LEVEL_COLS);
`endif
  end

  // State registers; reset discards any partial column.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StFetch;
      row_q       <= '0;
      rom_addr_q  <= '0;
      back_q      <= '0;
      front_q     <= '0;
      back_full_q <= 1'b0;
      col_valid_q <= 1'b0;
      front_col_q <= '0;
      level_end_q <= 1'b0;
      underrun_q  <= 1'b0;
      air_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      rom_addr_q  <= rom_addr_d;
      back_q      <= back_d;
      front_q     <= front_d;
      back_full_q <= back_full_d;
      col_valid_q <= col_valid_d;
      front_col_q <= front_col_d;
      level_end_q <= level_end_d;
      underrun_q  <= underrun_d;
      air_q       <= air_d;
      wrap_q      <= wrap_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign new_block_id = front_q;
  assign col_valid    = col_valid_q;
  assign front_col    = front_col_q;
  assign level_end    = level_end_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_level_column_feeder.sv
// Directed bench for level_column_feeder with a 4-column level (LEVEL_COLS=4).
// ROM cell (c,r) = (c+r) mod 8. Honours LEVEL_LOOP_EN if defined at compile time.
module tb_level_column_feeder;

  localparam int unsigned NR = 10;
  localparam int unsigned CW = 3;
  localparam int unsigned LC = 4;
  localparam int unsigned AW = 12;

  logic             clk;
  logic             rst_n;
  logic             shift;
  logic [AW-1:0]    rom_addr;
  logic [CW-1:0]    rom_data;
  logic [NR*CW-1:0] new_block_id;
  logic             col_valid;
  logic [7:0]       front_col;
  logic             level_end;
  logic             underrun;

  int vectors;
  int miscompares;

  level_column_feeder #(
    .NUM_ROWS  (NR),
    .CELL_W    (CW),
    .LEVEL_COLS(LC),
    .ADDR_W    (AW)
  ) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Shift       (shift),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .new_block_id(new_block_id),
    .col_valid   (col_valid),
    .front_col   (front_col),
    .level_end   (level_end),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] rom_cell(input logic [AW-1:0] a);
    int c, r;
    c = int'(a) / NR;
    r = int'(a) % NR;
    return CW'((c + r) % 8);
  endfunction

  function automatic logic [NR*CW-1:0] col_word(input int c);
    logic [NR*CW-1:0] w;
    w = '0;
    for (int r = 0; r < NR; r++) w[CW*r +: CW] = CW'((c + r) % 8);
    return w;
  endfunction

  // Synchronous ROM, one cycle read latency
  always @(posedge clk) rom_data <= rom_cell(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_shift();
    shift = 1'b1;
    tick();
    shift = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    shift = 1'b0;
    repeat (3) tick();
    vectors++; if (col_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_col_valid: got %0b want 0", col_valid); end
    vectors++; if (front_col !== 8'd0) begin miscompares++;
      $display("FAIL reset_front_col: got %0d want 0", front_col); end
    vectors++; if (rom_addr !== 12'd0) begin miscompares++;
      $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    vectors++; if (new_block_id !== 30'd0) begin miscompares++;
      $display("FAIL reset_block_id: got %o want 0", new_block_id); end
    vectors++; if (level_end !== 1'b0) begin miscompares++;
      $display("FAIL reset_level_end: got %0b want 0", level_end); end
    vectors++; if (underrun !== 1'b0) begin miscompares++;
      $display("FAIL reset_underrun: got %0b want 0", underrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_column();
    repeat (10) tick();
    vectors++; if (col_valid !== 1'b0) begin miscompares++;
      $display("FAIL first_not_yet_valid: got %0b want 0", col_valid); end
    vectors++; if (rom_addr !== 12'd9) begin miscompares++;
      $display("FAIL first_last_addr: got %0d want 9", rom_addr); end
    tick();
    vectors++; if (col_valid !== 1'b1) begin miscompares++;
      $display("FAIL first_valid: got %0b want 1", col_valid); end
    vectors++; if (new_block_id !== col_word(0)) begin miscompares++;
      $display("FAIL first_data: got %o want %o", new_block_id, col_word(0)); end
    vectors++; if (front_col !== 8'd0) begin miscompares++;
      $display("FAIL first_front_col: got %0d want 0", front_col); end
    vectors++; if (rom_addr !== 12'd10) begin miscompares++;
      $display("FAIL first_next_addr: got %0d want 10", rom_addr); end
  endtask

  task automatic test_shift_swap();
    repeat (30) tick();
    vectors++; if (rom_addr !== 12'd19) begin miscompares++;
      $display("FAIL hold_addr: got %0d want 19", rom_addr); end
    pulse_shift();
    vectors++; if (new_block_id !== col_word(1)) begin miscompares++;
      $display("FAIL swap_data: got %o want %o", new_block_id, col_word(1)); end
    vectors++; if (front_col !== 8'd1) begin miscompares++;
      $display("FAIL swap_front_col: got %0d want 1", front_col); end
    vectors++; if (col_valid !== 1'b1) begin miscompares++;
      $display("FAIL swap_valid: got %0b want 1", col_valid); end
    vectors++; if (rom_addr !== 12'd20) begin miscompares++;
      $display("FAIL swap_addr: got %0d want 20", rom_addr); end
    for (int i = 1; i <= 11; i++) begin
      tick();
      vectors++; if (rom_addr !== AW'((20 + i > 29) ? 29 : 20 + i)) begin miscompares++;
        $display("FAIL refetch_addr[%0d]: got %0d want %0d", i, rom_addr,
                 (20 + i > 29) ? 29 : 20 + i); end
    end
  endtask

  task automatic test_underrun();
    pulse_shift();
    vectors++; if (new_block_id !== col_word(2) || front_col !== 8'd2) begin miscompares++;
      $display("FAIL ur_swap: got %o/%0d want %o/2", new_block_id, front_col, col_word(2)); end
    repeat (2) tick();
    pulse_shift();
    vectors++; if (col_valid !== 1'b0) begin miscompares++;
      $display("FAIL ur_drop_valid: got %0b want 0", col_valid); end
    vectors++; if (front_col !== 8'd3) begin miscompares++;
      $display("FAIL ur_drop_front_col: got %0d want 3", front_col); end
    vectors++; if (new_block_id !== col_word(2)) begin miscompares++;
      $display("FAIL ur_stale_data: got %o want %o", new_block_id, col_word(2)); end
    tick();
    pulse_shift();
    vectors++; if (underrun !== 1'b1) begin miscompares++;
      $display("FAIL ur_flag: got %0b want 1", underrun); end
    vectors++; if (front_col !== 8'd3) begin miscompares++;
      $display("FAIL ur_front_col_kept: got %0d want 3", front_col); end
    repeat (6) tick();
    vectors++; if (col_valid !== 1'b1 || new_block_id !== col_word(3)) begin miscompares++;
      $display("FAIL ur_refill: got %0b/%o want 1/%o", col_valid, new_block_id, col_word(3)); end
    vectors++; if (level_end !== 1'b0) begin miscompares++;
      $display("FAIL ur_level_end: got %0b want 0", level_end); end
`ifdef LEVEL_LOOP_EN
    vectors++; if (rom_addr !== 12'd0) begin miscompares++;
      $display("FAIL wrap_addr: got %0d want 0", rom_addr); end
`else
    vectors++; if (rom_addr !== 12'd39) begin miscompares++;
      $display("FAIL end_addr: got %0d want 39", rom_addr); end
`endif
  endtask

  task automatic test_level_end();
    repeat (15) tick();
    pulse_shift();
`ifdef LEVEL_LOOP_EN
    vectors++; if (new_block_id !== col_word(0) || front_col !== 8'd0) begin miscompares++;
      $display("FAIL loop_col0: got %o/%0d want %o/0", new_block_id, front_col, col_word(0)); end
    vectors++; if (level_end !== 1'b1) begin miscompares++;
      $display("FAIL loop_pulse: got %0b want 1", level_end); end
    tick();
    vectors++; if (level_end !== 1'b0) begin miscompares++;
      $display("FAIL loop_pulse_end: got %0b want 0", level_end); end
    repeat (13) tick();
    pulse_shift();
    vectors++; if (new_block_id !== col_word(1) || front_col !== 8'd1) begin miscompares++;
      $display("FAIL loop_col1: got %o/%0d want %o/1", new_block_id, front_col, col_word(1)); end
`else
    vectors++; if (new_block_id !== 30'd0 || front_col !== 8'd4) begin miscompares++;
      $display("FAIL air_col4: got %o/%0d want 0/4", new_block_id, front_col); end
    vectors++; if (level_end !== 1'b1) begin miscompares++;
      $display("FAIL air_level_end: got %0b want 1", level_end); end
    tick();
    vectors++; if (level_end !== 1'b1 || rom_addr !== 12'd39) begin miscompares++;
      $display("FAIL air_hold: got %0b/%0d want 1/39", level_end, rom_addr); end
    repeat (13) tick();
    pulse_shift();
    vectors++; if (new_block_id !== 30'd0 || front_col !== 8'd5 || col_valid !== 1'b1)
      begin miscompares++;
      $display("FAIL air_col5: got %o/%0d/%0b want 0/5/1", new_block_id, front_col,
               col_valid); end
    vectors++; if (rom_addr !== 12'd39) begin miscompares++;
      $display("FAIL air_addr_frozen: got %0d want 39", rom_addr); end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    vectors++; if (rom_addr !== 12'd5) begin miscompares++;
      $display("FAIL mid_row5: got %0d want 5", rom_addr); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (rom_addr !== 12'd0 || col_valid !== 1'b0 || front_col !== 8'd0 ||
                   new_block_id !== 30'd0 || level_end !== 1'b0 || underrun !== 1'b0)
      begin miscompares++;
      $display("FAIL async_reset: got addr=%0d cv=%0b fc=%0d id=%o le=%0b ur=%0b want zeros",
               rom_addr, col_valid, front_col, new_block_id, level_end, underrun); end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (rom_addr !== 12'd1) begin miscompares++;
      $display("FAIL refetch_start: got %0d want 1", rom_addr); end
    repeat (10) tick();
    vectors++; if (col_valid !== 1'b1 || new_block_id !== col_word(0) || front_col !== 8'd0)
      begin miscompares++;
      $display("FAIL refetch_col0: got %0b/%o/%0d want 1/%o/0", col_valid, new_block_id,
               front_col, col_word(0)); end
  endtask

  task automatic test_shift_on_drain();
    repeat (10) tick();
    vectors++; if (col_valid !== 1'b1 || front_col !== 8'd0) begin miscompares++;
      $display("FAIL pre_drain: got %0b/%0d want 1/0", col_valid, front_col); end
    pulse_shift();
    vectors++; if (col_valid !== 1'b1) begin miscompares++;
      $display("FAIL drain_shift_valid: got %0b want 1", col_valid); end
    vectors++; if (front_col !== 8'd1 || new_block_id !== col_word(1)) begin miscompares++;
      $display("FAIL drain_shift_col: got %0d/%o want 1/%o", front_col, new_block_id,
               col_word(1)); end
    vectors++; if (underrun !== 1'b0) begin miscompares++;
      $display("FAIL drain_shift_underrun: got %0b want 0", underrun); end
    vectors++; if (rom_addr !== 12'd20) begin miscompares++;
      $display("FAIL drain_shift_addr: got %0d want 20", rom_addr); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    shift       = 1'b0;
    test_reset();
    test_first_column();
    test_shift_swap();
    test_underrun();
    test_level_end();
    test_reset_mid_fetch();
    test_shift_on_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
